// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Mode/setting controller for a digital clock. Four raw buttons are
//   synchronised and debounced. A rising edge of a debounced level is a press.
//   The presses drive a small FSM: RUN -> SET_H/SET_M/SET_S -> COMMIT -> RUN.
//   In a SET state the FSM emits one-cycle step pulses to the setting
//   registers. COMMIT emits a one-cycle PE load pulse. An idle timeout in a
//   SET state aborts back to RUN without PE.
//
//   Optional feature: define CLOCK_MODE_CTRL_AUTO_REPEAT_EN to enable
//   auto-repeat of UP/DOWN while the key is held.
//
// Ports
//   CP                  clock, rising edge
//   CR                  synchronous active-high reset
//   TICK                single-cycle enable from the divider (10 Hz nominal)
//   KEY_MODE/UP/DOWN/OK raw asynchronous buttons, active-high
//   PE                  one-cycle load pulse to the timer
//   H_/M_/S_ UP/DOWN    one-cycle step pulses to the setting registers
//   DISP_SEL            0 = running time shown, 1 = setting registers shown
//   BLINK[2:0]          {hour, minute, second} blank mask, 1 = blank
//   STATE[2:0]          current FSM state, for debug
//
// Handshake: there is no valid/ready flow control. Every output is a
// registered level or a single-cycle pulse, and nothing waits on a consumer.
module clock_mode_ctrl #(
  parameter int DEB_CYCLES    = 16,
  parameter int TIMEOUT_TICKS = 100,
  parameter int BLINK_TICKS   = 5,
  parameter int REPEAT_DLY    = 8,
  parameter int REPEAT_RATE   = 2
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  input  logic       KEY_OK,
  output logic       PE,
  output logic       H_UP,
  output logic       H_DOWN,
  output logic       M_UP,
  output logic       M_DOWN,
  output logic       S_UP,
  output logic       S_DOWN,
  output logic       DISP_SEL,
  output logic [2:0] BLINK,
  output logic [2:0] STATE
);

  localparam int DW = (DEB_CYCLES    > 1) ? $clog2(DEB_CYCLES)    : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS   > 1) ? $clog2(BLINK_TICKS)   : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_TICKS - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Key vector bit order: 0 = MODE, 1 = UP, 2 = DOWN, 3 = OK
  logic [3:0]    raw, sync1, sync2, deb, deb_d, armed, press;
  logic [DW-1:0] deb_cnt [4];

  assign raw = {KEY_OK, KEY_DOWN, KEY_UP, KEY_MODE};

  // Synchroniser flops carry no reset. A key held through reset then stays
  // visible as high, so it never arms (see below).
  always_ff @(posedge CP) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  // A key arms only after it has been seen low since reset. A key held
  // through reset release therefore needs a release before it can press.
  always_ff @(posedge CP) begin
    if (CR) begin
      deb   <= '0;
      deb_d <= '0;
      armed <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      armed <= armed | ~sync2;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_d & armed;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          any_press, step_up, step_down, rep_up, rep_down, rep_any;
  logic          timeout_hit, in_set;
  logic [2:0]    field_mask;

  assign STATE     = state;
  assign any_press = |press;
  assign in_set    = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign rep_any   = rep_up | rep_down;
  // Simultaneous UP and DOWN presses cancel each other out.
  assign step_up   = (press[1] & ~press[2]) | rep_up;
  assign step_down = (press[2] & ~press[1]) | rep_down;
  // Any activity, including a repeat step, restarts the idle timeout.
  assign timeout_hit = TICK && (tcnt == TO_MAX) && !any_press && !rep_any;

  always_comb begin
    field_mask = 3'b000;
    case (state)
      SET_H:   field_mask = 3'b100;
      SET_M:   field_mask = 3'b010;
      SET_S:   field_mask = 3'b001;
      default: field_mask = 3'b000;
    endcase
  end

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_MAX  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_started, hold_up, hold_down, rep_fire;

  assign hold_up   = deb[1] & ~deb[2] & armed[1];
  assign hold_down = deb[2] & ~deb[1] & armed[2];
  // The first REPEAT_DLY ticks of a hold are the delay phase and emit
  // nothing. After that, a step fires every REPEAT_RATE ticks.
  assign rep_fire  = in_set && rep_started && TICK && (rep_cnt == RATE_MAX) &&
                     !any_press;
  assign rep_up    = rep_fire & hold_up;
  assign rep_down  = rep_fire & hold_down;

  always_ff @(posedge CP) begin
    if (CR || !in_set || !(hold_up || hold_down) || any_press) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (TICK) begin
      if (rep_cnt == (rep_started ? RATE_MAX : DLY_MAX)) begin
        rep_cnt     <= '0;
        rep_started <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (CR) begin
      state    <= RUN;
      PE       <= 1'b0;
      H_UP     <= 1'b0;
      H_DOWN   <= 1'b0;
      M_UP     <= 1'b0;
      M_DOWN   <= 1'b0;
      S_UP     <= 1'b0;
      S_DOWN   <= 1'b0;
      DISP_SEL <= 1'b0;
      BLINK    <= 3'b000;
      tcnt     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
    end else begin
      PE     <= 1'b0;
      H_UP   <= 1'b0;
      H_DOWN <= 1'b0;
      M_UP   <= 1'b0;
      M_DOWN <= 1'b0;
      S_UP   <= 1'b0;
      S_DOWN <= 1'b0;
      case (state)
        RUN: begin
          BLINK <= 3'b000;
          tcnt  <= '0;
          bcnt  <= '0;
          phase <= 1'b0;
          if (press[0]) begin
            state    <= SET_H;
            DISP_SEL <= 1'b1;
          end else begin
            DISP_SEL <= 1'b0;
          end
        end
        SET_H, SET_M, SET_S: begin
          if (press[3]) begin
            // OK has priority over a MODE press in the same cycle.
            state <= COMMIT;
            PE    <= 1'b1;
            BLINK <= 3'b000;
            tcnt  <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
          end else if (press[0]) begin
            case (state)
              SET_H:   state <= SET_M;
              SET_M:   state <= SET_S;
              default: state <= SET_H;
            endcase
            BLINK <= 3'b000;
            tcnt  <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
          end else if (timeout_hit) begin
            state    <= RUN;
            DISP_SEL <= 1'b0;
            BLINK    <= 3'b000;
            tcnt     <= '0;
            bcnt     <= '0;
            phase    <= 1'b0;
          end else begin
            case (state)
              SET_H: begin
                H_UP   <= step_up;
                H_DOWN <= step_down;
              end
              SET_M: begin
                M_UP   <= step_up;
                M_DOWN <= step_down;
              end
              default: begin
                S_UP   <= step_up;
                S_DOWN <= step_down;
              end
            endcase
            if (any_press || rep_any) tcnt <= '0;
            else if (TICK)            tcnt <= tcnt + 1'b1;
            if (TICK) begin
              if (bcnt == BL_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
                BLINK <= phase ? 3'b000 : field_mask;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          state    <= RUN;
          DISP_SEL <= 1'b0;
          BLINK    <= 3'b000;
          tcnt     <= '0;
          bcnt     <= '0;
          phase    <= 1'b0;
        end
        default: begin
          state    <= RUN;
          DISP_SEL <= 1'b0;
          BLINK    <= 3'b000;
          tcnt     <= '0;
          bcnt     <= '0;
          phase    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl
//   Directed bench for clock_mode_ctrl with short debounce/timeout constants.
//   Pulse outputs are checked through an expected queue. Expected codes are
//   {PE, H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN}.
module tb_clock_mode_ctrl;

  localparam logic [6:0] P_PE     = 7'b1000000;
  localparam logic [6:0] P_H_DOWN = 7'b0010000;
  localparam logic [6:0] P_M_UP   = 7'b0001000;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_UP   = 4'b0010;
  localparam logic [3:0] K_DOWN = 4'b0100;
  localparam logic [3:0] K_OK   = 4'b1000;

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int N_DOWN = 8;
`else
  localparam int N_DOWN = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       cr = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic       pe, h_up, h_down, m_up, m_down, s_up, s_down, disp_sel;
  logic [2:0] blink, state;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .DEB_CYCLES(4), .TIMEOUT_TICKS(20), .BLINK_TICKS(2),
    .REPEAT_DLY(3), .REPEAT_RATE(1)
  ) dut (
    .CP(clk), .CR(cr), .TICK(tick),
    .KEY_MODE(keys[0]), .KEY_UP(keys[1]), .KEY_DOWN(keys[2]), .KEY_OK(keys[3]),
    .PE(pe), .H_UP(h_up), .H_DOWN(h_down), .M_UP(m_up), .M_DOWN(m_down),
    .S_UP(s_up), .S_DOWN(s_down), .DISP_SEL(disp_sel), .BLINK(blink),
    .STATE(state)
  );

  // ---------------- scoreboard ----------------
  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  logic [6:0] exp_q[$];
  logic [6:0] pv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    pv = {pe, h_up, h_down, m_up, m_down, s_up, s_down};
    if (pv != 7'd0) begin
      if (exp_q.size() > 0) chk("pulse", 32'(pv), 32'(exp_q.pop_front()));
      else                  chk("unexpected_pulse", 32'(pv), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_keys(input logic [3:0] k);
    keys = k;
    cycles(10);
    keys = 4'b0000;
    cycles(10);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cycles(3);
    cr = 1'b1;
    cycles(1);
    cr = 1'b0;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_disp", 32'(disp_sel), 32'd0);
    chk("reset_blink", 32'(blink), 32'd0);
    chk("reset_pe", 32'(pe), 32'd0);

    // MODE press: state changes exactly 7 cycles after the key rises
    keys = K_MODE;
    cycles(6);
    chk("mode_lat_before", 32'(state), 32'd0);
    cycles(1);
    chk("mode_lat_state", 32'(state), 32'd1);
    chk("mode_lat_disp", 32'(disp_sel), 32'd1);
    cycles(3);
    keys = 4'b0000;
    cycles(10);
    chk("set_h_hold", 32'(state), 32'd1);

    // SET_M: three UP presses, then OK
    press_keys(K_MODE);
    chk("set_m", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(P_M_UP);
      press_keys(K_UP);
    end
    chk("m_up_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(P_PE);
    keys = K_OK;
    cycles(6);
    chk("ok_before", 32'(state), 32'd2);
    cycles(1);
    chk("commit_state", 32'(state), 32'd4);
    chk("commit_pe", 32'(pe), 32'd1);
    chk("commit_disp", 32'(disp_sel), 32'd1);
    cycles(1);
    chk("post_commit_state", 32'(state), 32'd0);
    chk("post_commit_pe", 32'(pe), 32'd0);
    chk("post_commit_disp", 32'(disp_sel), 32'd0);
    cycles(3);
    keys = 4'b0000;
    cycles(10);

    // SET_S timeout with blink
    press_keys(K_MODE);
    press_keys(K_MODE);
    press_keys(K_MODE);
    chk("set_s", 32'(state), 32'd3);
    chk("set_s_blink0", 32'(blink), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      if (k < 20) begin
        chk("to_state", 32'(state), 32'd3);
        chk("to_blink", 32'(blink), ((k / 2) % 2 == 1) ? 32'd1 : 32'd0);
      end
    end
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_disp", 32'(disp_sel), 32'd0);
    chk("abort_blink", 32'(blink), 32'd0);

    // Glitch and simultaneous UP/DOWN in SET_H: no steps
    press_keys(K_MODE);
    chk("set_h_again", 32'(state), 32'd1);
    keys = K_UP;
    cycles(2);
    keys = 4'b0000;
    cycles(10);
    press_keys(K_UP | K_DOWN);
    chk("updown_state", 32'(state), 32'd1);

    // OK and MODE together: OK wins
    exp_q.push_back(P_PE);
    keys = K_OK | K_MODE;
    cycles(7);
    chk("okmode_state", 32'(state), 32'd4);
    chk("okmode_pe", 32'(pe), 32'd1);
    cycles(1);
    chk("okmode_run", 32'(state), 32'd0);
    keys = 4'b0000;
    cycles(10);

    // Reset on the edge that would enter COMMIT: no PE
    press_keys(K_MODE);
    chk("pre_cr_state", 32'(state), 32'd1);
    keys = K_OK;
    cycles(6);
    cr = 1'b1;
    cycles(1);
    cr = 1'b0;
    chk("cr_pe", 32'(pe), 32'd0);
    chk("cr_state", 32'(state), 32'd0);
    chk("cr_disp", 32'(disp_sel), 32'd0);
    cycles(5);
    keys = 4'b0000;
    cycles(10);

    // MODE held through reset release must not count as a press
    keys = K_MODE;
    cycles(3);
    cr = 1'b1;
    cycles(1);
    cr = 1'b0;
    cycles(15);
    chk("held_through_reset", 32'(state), 32'd0);
    keys = 4'b0000;
    cycles(10);
    press_keys(K_MODE);
    chk("repress_after_reset", 32'(state), 32'd1);

    // DOWN held for 10 ticks in SET_H
    for (int i = 0; i < N_DOWN; i++) exp_q.push_back(P_H_DOWN);
    keys = K_DOWN;
    cycles(10);
    for (int i = 0; i < 10; i++) do_tick();
    keys = 4'b0000;
    cycles(10);
    chk("h_down_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(P_PE);
    press_keys(K_OK);
    chk("final_state", 32'(state), 32'd0);
    cycles(5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
